mips_multicycle_core: RTL and testbench

Multi-cycle successor to the single-cycle MIPS datapath. It supports the same instruction set: add, addi, lw, sw, sll, and, andi, nor, beq, jal, jr, slt. The core uses one shared ALU, a single unified memory port with a req/ready handshake that tolerates wait states, and an internal FSM that sequences FETCH/DECODE/EXEC/MEM/WB. It sits between the top level and an external unified instruction/data memory.

---
 rtl/mips_multicycle_core.sv | 209 ++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one shared ALU, one unified memory port (req/ready),
// FSM sequencing FETCH/DECODE/EXEC/MEM/WB. Only one instruction in flight.
// Valid/ready: a transfer completes on a rising edge where mem_req && mem_ready;
// while mem_req is high and mem_ready is low, mem_addr/mem_we/mem_wdata hold.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          NUM_REGS        = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        retire,
   output logic [31:0] pc_out,
   output logic        halted,
   output logic        illegal,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                          OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_LW = 6'h23,
                          OP_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20,
                          FN_AND = 6'h24, FN_NOR = 6'h27, FN_SLT = 6'h2A;

   state_t      state;
   logic [31:0] pc, cur_pc, ir, a, b, bt, alu_out, mdr;
   logic [31:0] rf [NUM_REGS];

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh, wb_dst;
   logic [31:0] imm_sext, imm_zext, alu_res, beq_pc;
   logic        legal, wb_en;

   assign op       = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign sh       = ir[10:6];
   assign fn       = ir[5:0];
   assign imm_sext = {{16{ir[15]}}, ir[15:0]};
   assign imm_zext = {16'h0000, ir[15:0]};
   assign beq_pc   = (a == b) ? bt : pc;
   assign pc_out   = (state == S_FETCH) ? pc : cur_pc;
   assign state_dbg = state;

   // Classify the instruction register as a supported encoding or not.
   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE: legal = fn inside {FN_SLL, FN_JR, FN_ADD, FN_AND, FN_NOR, FN_SLT};
         OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   // Shared ALU: arithmetic, logic, compare and effective-address generation.
   always_comb begin
      alu_res = '0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD:  alu_res = a + b;
               FN_AND:  alu_res = a & b;
               FN_NOR:  alu_res = ~(a | b);
               FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
               FN_SLL:  alu_res = b << sh;
               default: alu_res = '0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_res = a + imm_sext;
         OP_ANDI: alu_res = a & imm_zext;
         default: alu_res = '0;
      endcase
   end

   // Write-back target: rd for R-type, rt for immediates and loads; jal and
   // NOP-treated illegal encodings pass through WB without writing.
   always_comb begin
      wb_dst = (op == OP_RTYPE) ? rd : rt;
      wb_en  = legal && (op != OP_JAL);
   end

   // Main sequencer with registered bus and status outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         cur_pc    <= RESET_PC;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         bt        <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= RESET_PC;
         mem_wdata <= '0;
         retire    <= 1'b0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               // After reset the request is raised here; otherwise it was
               // raised on the edge that entered FETCH.
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {pc[31:2], 2'b00};
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  cur_pc  <= pc;
                  pc      <= pc + 32'd4;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a  <= rf[rs];
               b  <= rf[rt];
               bt <= pc + {imm_sext[29:0], 2'b00};
               if (!legal) begin
                  illegal <= 1'b1;
                  if (HALT_ON_ILLEGAL) begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end else begin
                     state <= S_WB;
                  end
               end else if (op == OP_JAL) begin
                  rf[31] <= pc;
                  pc     <= {pc[31:28], ir[25:0], 2'b00};
                  state  <= S_WB;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               alu_out <= alu_res;
               if (op == OP_BEQ) begin
                  pc       <= beq_pc;
                  retire   <= 1'b1;
                  state    <= S_FETCH;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {beq_pc[31:2], 2'b00};
               end else if (op == OP_RTYPE && fn == FN_JR) begin
                  pc       <= a;
                  retire   <= 1'b1;
                  state    <= S_FETCH;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {a[31:2], 2'b00};
               end else if (op == OP_LW || op == OP_SW) begin
                  state     <= S_MEM;
                  mem_req   <= 1'b1;
                  mem_we    <= (op == OP_SW);
                  mem_addr  <= {alu_res[31:2], 2'b00};
                  mem_wdata <= b;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  if (op == OP_SW) begin
                     retire   <= 1'b1;
                     state    <= S_FETCH;
                     mem_addr <= {pc[31:2], 2'b00};
                  end else begin
                     mdr     <= mem_rdata;
                     mem_req <= 1'b0;
                     state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_en && wb_dst != 5'd0)
                  rf[wb_dst] <= (op == OP_LW) ? mdr : alu_out;
               retire   <= 1'b1;
               state    <= S_FETCH;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= {pc[31:2], 2'b00};
            end
            S_HALT: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
            end
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: directed programs plus random
// programs, checked against an instruction-level reference interpreter.
module tb_mips_multicycle_core;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] ILLEGAL_W = 32'hFC00_0000;

   logic        clock, reset_n;
   logic        mem_req, mem_we, mem_ready, retire, halted, illegal;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] ref_regs[0:31];
   logic [31:0] ref_pc;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];

   int          max_wait = 0;
   int          force_wait = -1;
   int          cur_wait = 0;
   int          wait_cnt = 0;
   int          waits_acc = 0;
   bit          req_active = 0;
   logic [31:0] hold_addr, hold_wdata;
   logic        hold_we;

   mips_multicycle_core dut (
      .clock(clock), .reset_n(reset_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .retire(retire), .pc_out(pc_out), .halted(halted), .illegal(illegal),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkint(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // memory responder: choose wait states, drive ready/rdata, check hold
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (reset_n && mem_req) begin
            if (!req_active) begin
               req_active = 1;
               wait_cnt   = 0;
               cur_wait   = (force_wait >= 0) ? force_wait : int'($urandom_range(max_wait, 0));
               hold_addr  = mem_addr;
               hold_we    = mem_we;
               hold_wdata = mem_wdata;
            end else begin
               check32("hold_addr", mem_addr, hold_addr);
               check32("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
               check32("hold_wdata", mem_wdata, hold_wdata);
            end
            mem_ready = (wait_cnt >= cur_wait);
            wait_cnt++;
            mem_rdata = mem[mem_addr[9:2]];
         end else begin
            mem_ready  = 1'b0;
            req_active = 0;
         end
      end
   end

   // memory accept: perform writes and log them
   initial begin
      forever begin
         @(posedge clock);
         if (!reset_n) begin
            req_active = 0;
         end else if (mem_req && mem_ready) begin
            check32("addr_align", mem_addr & 32'd3, 32'd0);
            if (mem_we) begin
               mem[mem_addr[9:2]] = mem_wdata;
               obs_q.push_back({mem_addr, mem_wdata});
            end
            waits_acc += cur_wait;
            req_active = 0;
         end
      end
   end

   // encoders
   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] enc_j(input int op, input int target);
      return {op[5:0], target[25:0]};
   endfunction

   task automatic put(input int addr, input logic [31:0] w);
      mem[addr >> 2]     = w;
      ref_mem[addr >> 2] = w;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
   endtask

   // store every register to 0x300 + 4*r, then an illegal word
   task automatic put_dump(input int start);
      for (int r = 0; r < 32; r++) put(start + 4 * r, enc_i(8'h2B, 0, r, 32'h300 + 4 * r));
      put(start + 128, ILLEGAL_W);
   endtask

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return mem[addr[9:2]];
   endfunction

   // reference interpreter
   function automatic bit ref_legal(input logic [31:0] w);
      case (w[31:26])
         6'h00:   return w[5:0] inside {6'h00, 6'h08, 6'h20, 6'h24, 6'h27, 6'h2A};
         6'h03, 6'h04, 6'h08, 6'h0C, 6'h23, 6'h2B: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic reg_w(input int r, input logic [31:0] v);
      if (r != 0) ref_regs[r] = v;
   endtask

   task automatic iss_step(output int lat);
      logic [31:0] ir, nxt, sx, zx, ea, va, vb;
      int rs, rt, rd, sh;
      ir = ref_mem[ref_pc[9:2]];
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      sh = int'(ir[10:6]);
      sx = {{16{ir[15]}}, ir[15:0]};
      zx = {16'h0000, ir[15:0]};
      va = ref_regs[rs];
      vb = ref_regs[rt];
      nxt = ref_pc + 32'd4;
      lat = 4;
      case (ir[31:26])
         6'h00: case (ir[5:0])
            6'h20: reg_w(rd, va + vb);
            6'h24: reg_w(rd, va & vb);
            6'h27: reg_w(rd, ~(va | vb));
            6'h2A: reg_w(rd, ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0);
            6'h00: reg_w(rd, vb << sh);
            6'h08: begin nxt = va; lat = 3; end
            default: ;
         endcase
         6'h08: reg_w(rt, va + sx);
         6'h0C: reg_w(rt, va & zx);
         6'h23: begin ea = va + sx; reg_w(rt, ref_mem[ea[9:2]]); lat = 5; end
         6'h2B: begin
            ea = va + sx;
            ref_mem[ea[9:2]] = vb;
            exp_q.push_back({ea & ~32'd3, vb});
         end
         6'h04: begin lat = 3; if (va == vb) nxt = nxt + (sx << 2); end
         6'h03: begin lat = 3; reg_w(31, nxt); nxt = {nxt[31:28], ir[25:0], 2'b00}; end
         default: ;
      endcase
      ref_pc = nxt;
   endtask

   // driver tasks
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check32({tag, "_req"}, {31'd0, mem_req}, 32'd0);
      check32({tag, "_we"}, {31'd0, mem_we}, 32'd0);
      check32({tag, "_retire"}, {31'd0, retire}, 32'd0);
      check32({tag, "_halted"}, {31'd0, halted}, 32'd0);
      check32({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
      check32({tag, "_addr"}, mem_addr, RESET_PC);
      check32({tag, "_wdata"}, mem_wdata, 32'd0);
      check32({tag, "_pc"}, pc_out, RESET_PC);
   endtask

   task automatic run_prog(input string tag, input int budget);
      int n, gap, base, icount, viol;
      bit done, first, saw_ret;
      logic [63:0] o, e;
      for (int i = 0; i < 32; i++) ref_regs[i] = '0;
      ref_pc = RESET_PC;
      exp_q.delete();
      obs_q.delete();
      waits_acc = 0;
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin @(negedge clock); n++; end
      check32({tag, "_first_fetch"}, mem_addr, RESET_PC);
      check32({tag, "_first_we"}, {31'd0, mem_we}, 32'd0);
      done = 0; first = 1; icount = 0;
      while (!done && icount < budget) begin
         if (!ref_legal(ref_mem[ref_pc[9:2]])) begin
            n = 0; saw_ret = 0;
            while (halted !== 1'b1 && n < 10) begin
               @(negedge clock); n++;
               if (retire === 1'b1) saw_ret = 1;
            end
            check32({tag, "_halted"}, {31'd0, halted}, 32'd1);
            check32({tag, "_illegal"}, {31'd0, illegal}, 32'd1);
            checkint({tag, "_retire_on_illegal"}, int'(saw_ret), 0);
            viol = 0;
            repeat (20) begin
               @(negedge clock);
               if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) viol++;
            end
            checkint({tag, "_halt_quiet"}, viol, 0);
            checkint({tag, "_stray_writes"}, obs_q.size(), 0);
            done = 1;
         end else begin
            gap = 0;
            do begin @(negedge clock); gap++; end while (retire !== 1'b1 && gap < 80);
            if (retire !== 1'b1) begin
               check32({tag, "_retire_timeout"}, {31'd0, retire}, 32'd1);
               done = 1;
            end else begin
               iss_step(base);
               if (!first) checkint({tag, "_latency"}, gap, base + waits_acc);
               waits_acc = 0;
               first = 0;
               check32({tag, "_pc"}, pc_out, ref_pc);
               checkint({tag, "_write_count"}, obs_q.size(), exp_q.size());
               while (obs_q.size() > 0 && exp_q.size() > 0) begin
                  o = obs_q.pop_front();
                  e = exp_q.pop_front();
                  check32({tag, "_waddr"}, o[63:32], e[63:32]);
                  check32({tag, "_wdata"}, o[31:0], e[31:0]);
               end
               obs_q.delete();
               exp_q.delete();
               icount++;
            end
         end
      end
      checkint({tag, "_completed"}, int'(done), 1);
   endtask

   task automatic build_random();
      int sel, rs, rt, rd;
      clear_mem();
      for (int i = 128; i < 192; i++) put(i * 4, $urandom);
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(9, 0);
         rs = $urandom_range(7, 0); rt = $urandom_range(7, 0); rd = $urandom_range(7, 0);
         case (sel)
            0: put(i * 4, enc_r(rs, rt, rd, 0, 32'h20));
            1: put(i * 4, enc_r(rs, rt, rd, 0, 32'h24));
            2: put(i * 4, enc_r(rs, rt, rd, 0, 32'h27));
            3: put(i * 4, enc_r(rs, rt, rd, 0, 32'h2A));
            4: put(i * 4, enc_r(0, rt, rd, $urandom_range(31, 0), 32'h00));
            5: put(i * 4, enc_i(32'h08, rs, rt, $urandom_range(16'hFFFF, 0)));
            6: put(i * 4, enc_i(32'h0C, rs, rt, $urandom_range(16'hFFFF, 0)));
            7: put(i * 4, enc_i(32'h23, 0, rt, 32'h200 + $urandom_range(255, 0)));
            8: put(i * 4, enc_i(32'h2B, 0, rt, 32'h200 + $urandom_range(255, 0)));
            default: put(i * 4, enc_i(32'h04, rs, rt, $urandom_range(2, 0)));
         endcase
      end
      put_dump(160);
   endtask

   // directed sequence
   initial begin
      int n;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);

      // arithmetic, $0 protection and shift, no wait states
      do_reset("rst0");
      clear_mem();
      put(32'h00, enc_i(32'h08, 0, 1, 5));
      put(32'h04, enc_i(32'h08, 0, 2, -3));
      put(32'h08, enc_r(1, 2, 3, 0, 32'h20));
      put(32'h0C, enc_r(2, 1, 4, 0, 32'h2A));
      put(32'h10, enc_r(0, 0, 5, 0, 32'h27));
      put(32'h14, enc_i(32'h08, 0, 0, 7));
      put(32'h18, enc_r(0, 1, 7, 4, 32'h00));
      put_dump(32'h1C);
      max_wait = 0; force_wait = -1;
      run_prog("arith", 100);
      check32("arith_r0", word_at(32'h300), 32'd0);
      check32("arith_r3", word_at(32'h30C), 32'd2);
      check32("arith_r4", word_at(32'h310), 32'd1);
      check32("arith_r5", word_at(32'h314), 32'hFFFF_FFFF);
      check32("arith_r7", word_at(32'h31C), 32'h50);

      // load/store with two wait states per transfer
      do_reset("rst1");
      clear_mem();
      put(32'h00, enc_i(32'h08, 0, 3, 2));
      put(32'h04, enc_j(32'h03, 32'h10));
      put(32'h40, enc_i(32'h2B, 0, 3, 8));
      put(32'h44, enc_i(32'h23, 0, 6, 8));
      put_dump(32'h48);
      force_wait = 2;
      run_prog("ldst", 100);
      force_wait = -1;
      check32("ldst_mem8", word_at(32'h008), 32'd2);
      check32("ldst_r6", word_at(32'h318), 32'd2);

      // control flow with random wait states
      do_reset("rst2");
      clear_mem();
      put(32'h00, enc_i(32'h08, 0, 1, 1));
      put(32'h04, enc_i(32'h04, 1, 1, 2));
      put(32'h08, ILLEGAL_W);
      put(32'h0C, ILLEGAL_W);
      put(32'h10, enc_j(32'h03, 32'h40));
      put_dump(32'h14);
      put(32'h100, enc_i(32'h04, 1, 2, 2));
      put(32'h104, enc_r(31, 0, 0, 0, 32'h08));
      max_wait = 2;
      run_prog("ctrl", 100);
      check32("ctrl_r31", word_at(32'h37C), 32'h14);

      // random programs
      for (int k = 0; k < 3; k++) begin
         do_reset("rst_rnd");
         build_random();
         max_wait = (k == 0) ? 0 : 2;
         run_prog("rand", 150);
      end

      // reset during a stalled load
      do_reset("rst3");
      clear_mem();
      put(32'h00, enc_i(32'h08, 0, 1, 9));
      put(32'h04, enc_i(32'h23, 0, 6, 32'h200));
      put(32'h08, ILLEGAL_W);
      force_wait = 30;
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr === 32'h200 && mem_we === 1'b0) && n < 300) begin
         @(negedge clock); n++;
      end
      check32("midrst_lw_seen", mem_addr, 32'h200);
      repeat (2) @(negedge clock);
      do_reset("midrst");
      force_wait = -1;
      max_wait = 1;
      clear_mem();
      put_dump(32'h00);
      run_prog("after_rst", 100);
      check32("after_rst_r1", word_at(32'h304), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
